round_referee: RTL and testbench

- Produces the per-round control stream the scorer consumes: winrnd, right, leds_on, tie.
- Synchronizes the two raw push buttons and times a pseudo-random light delay.
- Decides who pushed first, and whether the push was legal (light on) or a jump-the-light (light off).
- Sits between the button pins and the scorer. Stops launching rounds once the scorer reports a win.

---
 rtl/round_referee.sv | 224 ++++++++++++++++++++++
 tb/tb_round_referee.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// -----------------------------------------------------------------------------
// round_referee
//
// Reaction-game round controller. Synchronizes the two raw push buttons, waits
// a pseudo-random delay before lighting the lamp, then reports which player
// pushed first and whether the push was legal (lamp on) or a jump-the-light
// (lamp off). A hold-off period follows each reported round. No new round is
// launched while the scorer reports a finished game.
//
// Parameters:
//   MIN_WAIT    minimum WAIT length in cycles before the lamp lights
//   RAND_SHIFT  left shift applied to the LFSR sample added to MIN_WAIT
//   HOLDOFF     HOLD length after a reported round
//   LIGHT_MAX   lamp timeout in cycles (timeout build only)
//   CNT_W       width of the shared delay counter
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   pbl        in   raw left push button, asynchronous, active-high
//   pbr        in   raw right push button, asynchronous, active-high
//   game_over  in   scorer shows a win; blocks new rounds
//   winrnd     out  one-cycle pulse: a round result is valid
//   right      out  1 = right player pushed first (valid with winrnd)
//   leds_on    out  lamp; during winrnd, the lamp state at push time
//   tie        out  both pushes seen in the same cycle (only with winrnd)
//
// Build option:
//   REFEREE_TIMEOUT_EN  when defined, an unanswered lamp is voided after
//                       LIGHT_MAX cycles and a fresh round starts.
// -----------------------------------------------------------------------------
module round_referee #(
   parameter int MIN_WAIT   = 16,
   parameter int RAND_SHIFT = 2,
   parameter int HOLDOFF    = 64,
   parameter int LIGHT_MAX  = 1024,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pbl,
   input  logic pbr,
   input  logic game_over,
   output logic winrnd,
   output logic right,
   output logic leds_on,
   output logic tie
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LIGHT,
      S_REPORT,
      S_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] LP_MIN_WAIT   = CNT_W'(MIN_WAIT);
   localparam logic [CNT_W-1:0] LP_HOLDOFF    = CNT_W'(HOLDOFF);
   localparam logic [CNT_W-1:0] LP_LIGHT_LAST = CNT_W'(LIGHT_MAX - 1);
   localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

   // Button front end
   logic r_pbl_s1, r_pbl_s2, r_pbl_prev, r_pl;
   logic r_pbr_s1, r_pbr_s2, r_pbr_prev, r_pr;

   // Random source
   logic [7:0]       r_lfsr;
   logic             w_lfsr_fb;
   logic [CNT_W-1:0] w_wait_load;

   // FSM state and registered outputs
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_winrnd, w_winrnd_nxt;
   logic             r_right, w_right_nxt;
   logic             r_leds_on, w_leds_on_nxt;
   logic             r_tie, w_tie_nxt;
   logic             w_push;

   // Two-flop synchronizer, previous-value stage, then a registered rising
   // edge flag. A held button produces exactly one r_pl / r_pr pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pbl_s1   <= 1'b0;
         r_pbl_s2   <= 1'b0;
         r_pbl_prev <= 1'b0;
         r_pl       <= 1'b0;
         r_pbr_s1   <= 1'b0;
         r_pbr_s2   <= 1'b0;
         r_pbr_prev <= 1'b0;
         r_pr       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the value from
         // before the edge, so the synchronizer chain shifts by one stage per clock.
         r_pbl_s1   <= pbl;
         r_pbl_s2   <= r_pbl_s1;
         r_pbl_prev <= r_pbl_s2;
         r_pl       <= r_pbl_s2 & ~r_pbl_prev;
         r_pbr_s1   <= pbr;
         r_pbr_s2   <= r_pbr_s1;
         r_pbr_prev <= r_pbr_s2;
         r_pr       <= r_pbr_s2 & ~r_pbr_prev;
      end
   end

   // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1. Seeded non-zero, so it never
   // locks up at 0.
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      end
   end

   assign w_wait_load = LP_MIN_WAIT + (CNT_W'(r_lfsr) << RAND_SHIFT);
   assign w_push      = r_pl | r_pr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_winrnd  <= 1'b0;
         r_right   <= 1'b0;
         r_leds_on <= 1'b0;
         r_tie     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_winrnd  <= w_winrnd_nxt;
         r_right   <= w_right_nxt;
         r_leds_on <= w_leds_on_nxt;
         r_tie     <= w_tie_nxt;
      end
   end

   // Outputs are decoded from the transition being taken, so they change on
   // the same edge as the state they belong to.
   always_comb begin
      // NOTE: every signal gets a default before the case statement; a path
      // that leaves one unassigned would infer a latch.
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_winrnd_nxt  = 1'b0;
      w_tie_nxt     = 1'b0;
      w_right_nxt   = r_right;
      w_leds_on_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!r_pbl_s2 && !r_pbr_s2 && !game_over) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = w_wait_load;
            end
         end

         S_WAIT: begin
            // A push on the very cycle the delay expires still counts as a
            // jump-the-light: the push check has priority.
            if (w_push) begin
               w_state_nxt  = S_REPORT;
               w_winrnd_nxt = 1'b1;
               w_tie_nxt    = r_pl & r_pr;
               w_right_nxt  = r_pr & ~r_pl;
            end else if (r_cnt == '0) begin
               w_state_nxt   = S_LIGHT;
               w_leds_on_nxt = 1'b1;
               w_cnt_nxt     = '0;
            end else begin
               w_cnt_nxt = r_cnt - LP_ONE;
            end
         end

         S_LIGHT: begin
            w_leds_on_nxt = 1'b1;
            // The count stops at LIGHT_MAX-1 so a long wait never wraps it.
            if (r_cnt != LP_LIGHT_LAST) begin
               w_cnt_nxt = r_cnt + LP_ONE;
            end
            if (w_push) begin
               w_state_nxt  = S_REPORT;
               w_winrnd_nxt = 1'b1;
               w_tie_nxt    = r_pl & r_pr;
               w_right_nxt  = r_pr & ~r_pl;
            end
`ifdef REFEREE_TIMEOUT_EN
            else if (r_cnt == LP_LIGHT_LAST) begin
               // Nobody answered the lamp: void the round without a report.
               w_state_nxt   = S_IDLE;
               w_leds_on_nxt = 1'b0;
               w_cnt_nxt     = '0;
            end
`endif
         end

         S_REPORT: begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = LP_HOLDOFF;
         end

         S_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - LP_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign winrnd  = r_winrnd;
   assign right   = r_right;
   assign leds_on = r_leds_on;
   assign tie     = r_tie;

endmodule

// File: tb/tb_round_referee.sv
// -----------------------------------------------------------------------------
// tb_round_referee
//
// Scoreboard bench for round_referee. The reference model is a timeline: for
// each round it knows the cycle the round leaves IDLE, takes the LFSR sample
// from its own LFSR history, and from that derives the lamp-on cycle. A push
// whose edge reaches the FSM before that cycle is a jump-the-light; the report
// lands four clocks after the pin edge. Expected reports are queued by the
// driver and checked by an independent monitor whenever winrnd is seen.
// -----------------------------------------------------------------------------
module tb_round_referee;

   localparam int MIN_WAIT   = 4;
   localparam int RAND_SHIFT = 0;
   localparam int HOLDOFF    = 8;
   localparam int LIGHT_MAX  = 32;
   localparam int HIST_N     = 40000;

   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic pbl       = 1'b0;
   logic pbr       = 1'b0;
   logic game_over = 1'b0;
   logic winrnd, right, leds_on, tie;

   round_referee #(
      .MIN_WAIT   (MIN_WAIT),
      .RAND_SHIFT (RAND_SHIFT),
      .HOLDOFF    (HOLDOFF),
      .LIGHT_MAX  (LIGHT_MAX),
      .CNT_W      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pbl       (pbl),
      .pbr       (pbr),
      .game_over (game_over),
      .winrnd    (winrnd),
      .right     (right),
      .leds_on   (leds_on),
      .tie       (tie)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic right;
      logic leds;
      logic tie;
   } exp_t;

   exp_t sb[$];
   exp_t e_m;

   int   n_cmp      = 0;
   int   n_bad      = 0;
   int   cyc        = 0;
   int   exp_light  = -1;
   int   n_win      = 0;
   int   last_r     = -100;
   logic last_right = 1'b0;
   logic prev_win   = 1'b0;
   logic prev_leds  = 1'b0;

   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] hist [0:HIST_N-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Polynomial x^8+x^6+x^5+x^4+1: feedback is the parity of bits 7,5,4,3.
   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      return {x[6:0], ^(x & 8'hB8)};
   endfunction

   // cyc = number of rising edges so far; hist[c] = LFSR value after edge c.
   always @(posedge clk) begin
      cyc++;
      if (rst) m_lfsr = lfsr_step(m_lfsr);
      else     m_lfsr = 8'hA5;
      if (cyc < HIST_N) hist[cyc] = m_lfsr;
   end

   always @(negedge rst) begin
      m_lfsr = 8'hA5;
      if (cyc < HIST_N) hist[cyc] = 8'hA5;
   end

   // Lamp-on edge for a round that leaves IDLE at edge s: the WAIT counter is
   // loaded with MIN_WAIT + sample and runs down to 0 inclusive.
   function automatic int light_of(input int s);
      return s + MIN_WAIT + (int'(hist[s-1]) << RAND_SHIFT) + 1;
   endfunction

   // Advance to 1 time unit after rising edge c.
   task automatic wait_cyc(input int c);
      if (cyc > c) check("schedule", cyc, c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // kind: 0 left, 1 right, 2 tie.
   // mode: 0 random push time, 1 around the lamp boundary, 2 three cycles
   //       into the lamp, 3 early in WAIT.
   // hold_rel: 0 releases the buttons right after the report; otherwise the
   //           buttons stay held until hold_rel cycles after the report.
   task automatic do_round(input int s, input int kind, input int mode,
                           input int hold_rel, output int next_s);
      int   light, l, p;
      exp_t e;
      wait_cyc(s);
      light = light_of(s);
      l     = light - s - 1;
      case (mode)
         0:       p = s + $urandom_range(0, l + 6);
         1:       p = light - 4 + $urandom_range(0, 1);
         2:       p = light + 3;
         default: p = s + $urandom_range(0, 1);
      endcase
      e.cyc   = p + 4;
      e.right = (kind == 1);
      e.tie   = (kind == 2);
      // The edge flag is seen by the FSM in cycle p+3; lamp is on from 'light'.
      e.leds  = (p + 3 >= light);
      exp_light = e.leds ? light : -1;
      wait_cyc(p);
      pbl = (kind != 1);
      pbr = (kind != 0);
      sb.push_back(e);
      if (hold_rel == 0) begin
         wait_cyc(p + 5);
         pbl = 1'b0;
         pbr = 1'b0;
         // REPORT at p+4, HOLDOFF+1 HOLD cycles, one IDLE cycle.
         next_s = p + 4 + HOLDOFF + 3;
      end else begin
         wait_cyc(p + 4 + hold_rel);
         pbl = 1'b0;
         pbr = 1'b0;
         // Release reaches the second synchronizer flop two edges later.
         next_s = p + 4 + hold_rel + 3;
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         prev_win  = 1'b0;
         prev_leds = 1'b0;
      end else begin
         if (winrnd) begin
            n_win++;
            check("winrnd_expected", sb.size() > 0, 1'b1);
            check("winrnd_gap", prev_win, 1'b0);
            if (sb.size() > 0) begin
               e_m = sb.pop_front();
               check("winrnd_cycle", cyc, e_m.cyc);
               check("right", right, e_m.right);
               check("leds_at_push", leds_on, e_m.leds);
               check("tie", tie, e_m.tie);
               last_r     = cyc;
               last_right = e_m.right;
            end
         end
         if (tie) check("tie_with_winrnd", winrnd, 1'b1);
         if (leds_on && !prev_leds) check("light_on_cycle", cyc, exp_light);
         if (cyc > last_r && cyc <= last_r + HOLDOFF) begin
            check("hold_leds_off", leds_on, 1'b0);
            check("hold_right_kept", right, last_right);
         end
         prev_win  = winrnd;
         prev_leds = leds_on;
      end
   end

   initial begin
      int   s, ns, lt, p, w0, cnt;
      exp_t e;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_winrnd", winrnd, 1'b0);
      check("reset_right", right, 1'b0);
      check("reset_leds", leds_on, 1'b0);
      check("reset_tie", tie, 1'b0);
      #2 rst = 1'b1;
      s = cyc + 1;

      do_round(s, 1, 2, 0, ns); s = ns;   // legal right, 3 cycles into lamp
      do_round(s, 0, 3, 0, ns); s = ns;   // jump-the-light, left
      do_round(s, 2, 2, 0, ns); s = ns;   // tie during lamp
      for (int i = 0; i < 20; i++) begin
         do_round(s, $urandom_range(0, 2), (i % 4 == 3) ? 1 : 0, 0, ns);
         s = ns;
      end
      do_round(s, 1, 2, 20, ns); s = ns;  // right held well past HOLD

      // Reset in the middle of a lit lamp.
      wait_cyc(s);
      lt = light_of(s);
      exp_light = lt;
      wait_cyc(lt + 5);
      check("lamp_before_reset", leds_on, 1'b1);
      #1 rst = 1'b0;
      #1;
      check("midreset_winrnd", winrnd, 1'b0);
      check("midreset_right", right, 1'b0);
      check("midreset_leds", leds_on, 1'b0);
      check("midreset_tie", tie, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      s = cyc + 1;
      do_round(s, 0, 2, 0, ns); s = ns;   // first round after reset uses seed A5

      // Unanswered lamp.
      wait_cyc(s);
      lt = light_of(s);
      exp_light = lt;
      wait_cyc(lt);
      cnt = 0;
`ifdef REFEREE_TIMEOUT_EN
      for (int i = 0; i < LIGHT_MAX + 1; i++) begin
         cnt += int'(leds_on);
         @(posedge clk);
         #1;
      end
      check("timeout_lamp_cycles", cnt, LIGHT_MAX);
      s = lt + LIGHT_MAX + 1;
      wait_cyc(s);
      lt = light_of(s);
      exp_light = lt;
`else
      for (int i = 0; i < 2000; i++) begin
         cnt += int'(leds_on);
         @(posedge clk);
         #1;
      end
      check("no_timeout_lamp_cycles", cnt, 2000);
`endif
      if (cyc < lt + 2) wait_cyc(lt + 2);

      // game_over rises mid-lamp: this round still reports, then none follow.
      game_over = 1'b1;
      p = cyc;
      e = '{p + 4, 1'b1, 1'b1, 1'b0};
      sb.push_back(e);
      pbr = 1'b1;
      wait_cyc(p + 5);
      pbr = 1'b0;
      w0 = n_win;
      for (int i = 0; i < 500; i++) begin
         pbl = 1'($urandom_range(0, 1));
         pbr = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      check("game_over_no_winrnd", n_win - w0, 0);
      check("game_over_lamp_off", leds_on, 1'b0);
      pbl = 1'b0;
      pbr = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
